// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one pipelined adder among NUM_REQ requesters.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int SUM_W   = DATA_W + 1,
    parameter int ADD_LAT = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_1_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_2_i,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [SUM_W-1:0]            rsp_sum_o,
    output logic [DATA_W-1:0]           add_data_1_o,
    output logic [DATA_W-1:0]           add_data_2_o,
    input  logic [SUM_W-1:0]            add_sum_i,
    output logic                        busy_o
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    // Valid/ready: a request from k is accepted on the edge where
    // req_valid_i[k] & req_ready_o[k]; ready never depends on a response.
    logic            gnt;
    logic [ID_W-1:0] gnt_id;

    logic [DATA_W-1:0] add_data_1_q;
    logic [DATA_W-1:0] add_data_2_q;

    // Tag pipeline: stage ADD_LAT is aligned with add_sum_i.
    logic [ADD_LAT:0] tag_vld_q;
    logic [ID_W-1:0]  tag_id_q [0:ADD_LAT];

`ifndef ADDER_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
`endif

    always_comb begin
        gnt    = 1'b0;
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            if (!gnt && req_valid_i[i]) begin
                gnt    = 1'b1;
                gnt_id = ID_W'(i);
            end
`else
            if (!gnt && req_valid_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                gnt    = 1'b1;
                gnt_id = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            end
`endif
        end
        if (rst_i) begin
            gnt    = 1'b0;
            gnt_id = '0;
        end
    end

    assign req_ready_o = gnt ? (ONE_HOT_0 << gnt_id) : '0;

`ifndef ADDER_ARB_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (gnt) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            add_data_1_q <= '0;
            add_data_2_q <= '0;
            tag_vld_q    <= '0;
            for (int i = 0; i <= ADD_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            // Operands hold when idle so the adder inputs do not toggle.
            if (gnt) begin
                add_data_1_q <= req_data_1_i[int'(gnt_id)*DATA_W +: DATA_W];
                add_data_2_q <= req_data_2_i[int'(gnt_id)*DATA_W +: DATA_W];
            end
            tag_vld_q   <= {tag_vld_q[ADD_LAT-1:0], gnt};
            tag_id_q[0] <= gnt_id;
            for (int i = 1; i <= ADD_LAT; i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    assign add_data_1_o = add_data_1_q;
    assign add_data_2_o = add_data_2_q;

    assign rsp_valid_o = tag_vld_q[ADD_LAT] ? (ONE_HOT_0 << tag_id_q[ADD_LAT]) : '0;
    assign rsp_sum_o   = tag_vld_q[ADD_LAT] ? add_sum_i : '0;
    assign busy_o      = |tag_vld_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter with a behavioural pipelined adder model.
// Expectations follow the build mode (ADDER_ARB_FIXED_PRIO_EN defined or not).
module tb_adder_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int SUM_W   = 9;
    localparam int ADD_LAT = 1;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                      clk;
    logic                      rst_i;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*DATA_W-1:0] req_data_1_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_2_i;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [SUM_W-1:0]          rsp_sum_o;
    logic [DATA_W-1:0]         add_data_1_o;
    logic [DATA_W-1:0]         add_data_2_o;
    logic [SUM_W-1:0]          add_sum_i;
    logic                      busy_o;

    adder_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SUM_W(SUM_W), .ADD_LAT(ADD_LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_1_i(req_data_1_i), .req_data_2_i(req_data_2_i),
        .rsp_valid_o(rsp_valid_o), .rsp_sum_o(rsp_sum_o),
        .add_data_1_o(add_data_1_o), .add_data_2_o(add_data_2_o),
        .add_sum_i(add_sum_i), .busy_o(busy_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // adder model: ADD_LAT register stages
    logic [SUM_W-1:0] add_pipe [0:ADD_LAT-1];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_data_1_o} + {1'b0, add_data_2_o};
        for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_sum_i = add_pipe[ADD_LAT-1];

    // scoreboard: {due cycle[44:13], one-hot id[12:9], sum[8:0]}
    localparam int W = 32 + NUM_REQ + SUM_W;
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0][W-1:13] == 32'(cyc)) begin
                e = exp_q.pop_front();
                check("rsp_valid", 32'(rsp_valid_o), 32'(e[12:9]));
                check("rsp_sum", 32'(rsp_sum_o), 32'(e[8:0]));
            end else begin
                if (exp_q.size() > 0 && exp_q[0][W-1:13] < 32'(cyc)) begin
                    e = exp_q.pop_front();
                    check("rsp_missing", 32'(cyc), e[W-1:13]);
                end
                check("rsp_idle_valid", 32'(rsp_valid_o), 32'd0);
                check("rsp_idle_sum", 32'(rsp_sum_o), 32'd0);
            end
        end
    end

    // driver: one cycle of stimulus, grant check, optional scoreboard push
    task automatic step(input logic r, input logic [3:0] v,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [3:0] eg, input logic [8:0] es, input bit push);
        rst_i        = r;
        req_valid_i  = v;
        req_data_1_i = d1;
        req_data_2_i = d2;
        @(negedge clk);
        check("req_ready", 32'(req_ready_o), 32'(eg));
        if (push) exp_q.push_back({32'(cyc + ADD_LAT + 1), eg, es});
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] D1_ALL = {8'd40, 8'd30, 8'd20, 8'd10};
    localparam logic [31:0] D2_ALL = {8'd4,  8'd3,  8'd2,  8'd1};

    initial begin
        logic [8:0] sums_all [0:3];
        logic [3:0] eg;
        sums_all[0] = 9'd11; sums_all[1] = 9'd22; sums_all[2] = 9'd33; sums_all[3] = 9'd44;

        rst_i = 1'b1; req_valid_i = '0; req_data_1_i = '0; req_data_2_i = '0;
        @(posedge clk);
        #1;
        // reset: ready stays low even with every requester valid
        step(1'b1, 4'hF, D1_ALL, D2_ALL, 4'h0, 9'd0, 1'b0);
        step(1'b1, 4'hF, D1_ALL, D2_ALL, 4'h0, 9'd0, 1'b0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_add_data_1", 32'(add_data_1_o), 32'd0);
        check("rst_add_data_2", 32'(add_data_2_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        mon_en = 1'b1;

        // all four valid: round robin 0,1,2,3,... or fixed 0 every cycle
        for (int i = 0; i < 8; i++) begin
            eg = FIXED ? 4'b0001 : 4'(1 << (i % 4));
            step(1'b0, 4'hF, D1_ALL, D2_ALL, eg, FIXED ? sums_all[0] : sums_all[i % 4], 1'b1);
        end

        // single request on req 2: 5 + 7
        step(1'b0, 4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, {8'd0, 8'd7, 8'd0, 8'd0}, 4'b0100, 9'd12, 1'b1);
        check("issue_data_1", 32'(add_data_1_o), 32'd5);
        check("issue_data_2", 32'(add_data_2_o), 32'd7);
        check("busy_c1", 32'(busy_o), 32'd1);
        step(1'b0, 4'h0, '0, '0, 4'h0, 9'd0, 1'b0);
        check("busy_c2", 32'(busy_o), 32'd1);
        check("hold_data_1", 32'(add_data_1_o), 32'd5);
        step(1'b0, 4'h0, '0, '0, 4'h0, 9'd0, 1'b0);
        check("busy_c3", 32'(busy_o), 32'd0);

        // lone req 0 back to back, including overflow 255+255
        step(1'b0, 4'b0001, 32'd255, 32'd255, 4'b0001, 9'd510, 1'b1);
        step(1'b0, 4'b0001, 32'd255, 32'd1,   4'b0001, 9'd256, 1'b1);
        step(1'b0, 4'b0001, 32'd0,   32'd0,   4'b0001, 9'd0,   1'b1);

        // req 1 alone moves ptr to 2, then 1 and 3 compete (wrap-around)
        step(1'b0, 4'b0010, {8'd0, 8'd0, 8'd50, 8'd0}, {8'd0, 8'd0, 8'd6, 8'd0}, 4'b0010, 9'd56, 1'b1);
        for (int i = 0; i < 3; i++) begin
            eg = FIXED ? 4'b0010 : ((i % 2 == 0) ? 4'b1000 : 4'b0010);
            step(1'b0, 4'b1010, {8'd100, 8'd0, 8'd1, 8'd0}, {8'd27, 8'd0, 8'd2, 8'd0},
                 eg, (eg == 4'b1000) ? 9'd127 : 9'd3, 1'b1);
        end

        // reset mid-operation: the in-flight req 2 op must never respond
        step(1'b0, 4'b0100, {8'd0, 8'd9, 8'd0, 8'd0}, {8'd0, 8'd9, 8'd0, 8'd0}, 4'b0100, 9'd18, 1'b0);
        step(1'b1, 4'hF, D1_ALL, D2_ALL, 4'h0, 9'd0, 1'b0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        // pointer restarts at 0
        step(1'b0, 4'hF, D1_ALL, D2_ALL, 4'b0001, 9'd11, 1'b1);
        step(1'b0, 4'hF, D1_ALL, D2_ALL, FIXED ? 4'b0001 : 4'b0010, FIXED ? 9'd11 : 9'd22, 1'b1);

        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, '0, '0, 4'h0, 9'd0, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
